// File: rtl/matrix_datapath.sv
//------------------------------------------------------------------------------
// Module      : matrix_datapath
// Description : Dot-product datapath; N products are accumulated into a
//               published result with a valid/ready hand-off and overrun flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module matrix_datapath #(
    parameter int DATA_W = 8,
    parameter int N      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_matrix,
    input  logic                  multiply_matrix,
    input  logic                  add,
    input  logic                  done,
    input  logic [DATA_W-1:0]     a_data,
    input  logic [DATA_W-1:0]     b_data,
    output logic [3:0]            entry_count,
    output logic [2*DATA_W+3:0]   result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  overrun
);

    localparam int         PROD_W     = 2 * DATA_W;
    localparam int         RES_W      = 2 * DATA_W + 4;
    localparam logic [3:0] LAST_ENTRY = 4'(N - 1);

    logic [PROD_W-1:0] slot [N];
    logic [PROD_W-1:0] product;
    logic [RES_W-1:0]  slot_sum;
    logic [RES_W-1:0]  acc;
    logic              mult_cycle;
    logic              add_cycle;

    assign mult_cycle = load_matrix & multiply_matrix;
    assign add_cycle  = add & ~multiply_matrix;
    assign product    = PROD_W'(a_data) * PROD_W'(b_data);

    // Four guard bits cover up to 16 full-scale products without overflow.
    always_comb begin
        slot_sum = '0;
        for (int i = 0; i < N; i++) begin
            slot_sum = slot_sum + RES_W'(slot[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry_count <= 4'd0;
            for (int i = 0; i < N; i++) begin
                slot[i] <= '0;
            end
        end else begin
            if (!multiply_matrix) begin
                entry_count <= 4'd0;
            end else if (mult_cycle) begin
                for (int i = 0; i < N; i++) begin
                    if (entry_count == 4'(i)) begin
                        slot[i] <= product;
                    end
                end
                entry_count <= (entry_count == LAST_ENTRY) ? 4'd0 : entry_count + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (add_cycle) begin
            acc <= slot_sum;
        end
    end

    // A new done always wins over consumption; overrun only when the old
    // value was still pending and not taken on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (done) begin
                result       <= acc;
                result_valid <= 1'b1;
                if (result_valid && !result_ready) begin
                    overrun <= 1'b1;
                end
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_matrix_datapath.sv
//------------------------------------------------------------------------------
// Module      : tb_matrix_datapath
// Description : Directed self-checking bench for matrix_datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_matrix_datapath;

    localparam int DATA_W = 8;
    localparam int N      = 8;
    localparam int RES_W  = 2 * DATA_W + 4;

    logic              clock;
    logic              reset;
    logic              load_matrix;
    logic              multiply_matrix;
    logic              add;
    logic              done;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [3:0]        entry_count;
    logic [RES_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;
    logic              overrun;

    int total_checks;
    int failed_checks;
    logic [RES_W-1:0] expected_q [$];

    matrix_datapath #(.DATA_W(DATA_W), .N(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .load_matrix    (load_matrix),
        .multiply_matrix(multiply_matrix),
        .add            (add),
        .done           (done),
        .a_data         (a_data),
        .b_data         (b_data),
        .entry_count    (entry_count),
        .result         (result),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .overrun        (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) else begin
            failed_checks++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int op_a(input int mode, input int i);
        case (mode)
            0: return 1;
            1: return 255;
            2: return i;
            default: return 2;
        endcase
    endfunction

    function automatic int op_b(input int mode, input int i);
        case (mode)
            0: return 1;
            1: return 255;
            2: return i + 1;
            default: return 3;
        endcase
    endfunction

    // Full controller sequence: N multiplies, one add, one done.
    task automatic run_op(input int mode, input logic ready_at_done, input bit check_idle);
        int exp_sum;
        logic [RES_W-1:0] popped;
        exp_sum = 0;
        for (int i = 0; i < N; i++) exp_sum += op_a(mode, i) * op_b(mode, i);
        expected_q.push_back(RES_W'(exp_sum));
        for (int i = 0; i < N; i++) begin
            load_matrix     = 1'b1;
            multiply_matrix = 1'b1;
            a_data          = DATA_W'(op_a(mode, i));
            b_data          = DATA_W'(op_b(mode, i));
            check("entry_count_seq", 32'(entry_count), 32'(i));
            @(posedge clock); #1;
        end
        load_matrix     = 1'b0;
        multiply_matrix = 1'b0;
        add             = 1'b1;
        a_data          = 8'hA5;
        b_data          = 8'h5A;
        check("entry_count_wrap", 32'(entry_count), 32'd0);
        @(posedge clock); #1;
        add = 1'b0;
        if (check_idle) check("valid_before_done", 32'(result_valid), 32'd0);
        done         = 1'b1;
        result_ready = ready_at_done;
        @(posedge clock); #1;
        done         = 1'b0;
        result_ready = 1'b0;
        popped = expected_q.pop_front();
        check("result_valid_after_done", 32'(result_valid), 32'd1);
        check("result_value", 32'(result), 32'(popped));
    endtask

    task automatic consume();
        result_ready = 1'b1;
        @(posedge clock); #1;
        result_ready = 1'b0;
        check("valid_cleared_by_ready", 32'(result_valid), 32'd0);
    endtask

    initial begin
        total_checks    = 0;
        failed_checks   = 0;
        reset           = 1'b0;
        load_matrix     = 1'b0;
        multiply_matrix = 1'b0;
        add             = 1'b0;
        done            = 1'b0;
        a_data          = '0;
        b_data          = '0;
        result_ready    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_entry_count", 32'(entry_count), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // All ones: result 8 on the tenth edge after the first multiply.
        run_op(0, 1'b0, 1'b1);
        check("ones_overrun", 32'(overrun), 32'd0);
        consume();
        check("result_held_after_consume", 32'(result), 32'd8);

        // Full-scale operands, then done+ready together while valid.
        run_op(1, 1'b0, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        check("result_stable_while_valid", 32'(result), 32'd520200);
        run_op(2, 1'b1, 1'b0);
        check("done_ready_overrun_clear", 32'(overrun), 32'd0);
        consume();

        // Back-to-back with no consumer sets the sticky overrun.
        run_op(0, 1'b0, 1'b0);
        check("first_no_overrun", 32'(overrun), 32'd0);
        run_op(3, 1'b0, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 4; i++) begin
            load_matrix     = 1'b1;
            multiply_matrix = 1'b1;
            a_data          = 8'd7;
            b_data          = 8'd9;
            @(posedge clock); #1;
        end
        check("mid_entry_count", 32'(entry_count), 32'd4);
        #2;
        reset = 1'b0;
        #1;
        check("async_entry_count", 32'(entry_count), 32'd0);
        check("async_valid", 32'(result_valid), 32'd0);
        check("async_overrun", 32'(overrun), 32'd0);
        check("async_result", 32'(result), 32'd0);
        load_matrix     = 1'b0;
        multiply_matrix = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        run_op(0, 1'b0, 1'b1);
        check("restart_overrun", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/matrix_datapath.md
MATRIX_DATAPATH -- requirements
Module: matrix_datapath

Interface
REQ-001 SHALL have parameter DATA_W, default 8: operand width in bits.
REQ-002 SHALL have parameter N, default 8: entries per dot product, legal range 2..16.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port load_matrix, input, 1: controller strobe, operands present this cycle.
REQ-006 SHALL have port multiply_matrix, input, 1: controller strobe, multiply this cycle.
REQ-007 SHALL have port add, input, 1: controller strobe, sum stored products.
REQ-008 SHALL have port done, input, 1: controller strobe, publish accumulated sum.
REQ-009 SHALL have port a_data, input, DATA_W: row operand.
REQ-010 SHALL have port b_data, input, DATA_W: column operand.
REQ-011 SHALL have port entry_count, output, 4: index of the product slot written this cycle; fed back to the controller.
REQ-012 SHALL have port result, output, 2*DATA_W+4: published dot product.
REQ-013 SHALL have port result_valid, output, 1: result holds an unconsumed value.
REQ-014 SHALL have port result_ready, input, 1: consumer accepts result.
REQ-015 SHALL have port overrun, output, 1: sticky flag, a published result was overwritten unconsumed.

Function
REQ-016 SHALL define a multiply cycle as load_matrix=1 and multiply_matrix=1; SHALL ignore operands in all other cycles.
REQ-017 SHALL, on a multiply cycle, register the unsigned product a_data*b_data (2*DATA_W bits) into slot[entry_count].
REQ-018 SHALL, on a multiply cycle, increment entry_count by 1; entry_count=N-1 SHALL wrap to 0.
REQ-019 SHALL clear entry_count to 0 on any cycle with multiply_matrix=0, so each operation starts at slot 0.
REQ-020 SHALL, on a cycle with add=1 and multiply_matrix=0, register into acc the unsigned sum of slots 0..N-1, zero-extended to 2*DATA_W+4 bits; the sum SHALL NOT overflow.
REQ-021 SHALL ignore add whenever multiply_matrix=1.
REQ-022 SHALL, on a cycle with done=1, copy acc to result and set result_valid=1 at that clock edge.
REQ-023 SHALL hold result stable while result_valid=1 unless a new done cycle occurs.
REQ-024 SHALL clear result_valid at the edge where result_valid=1 and result_ready=1 and done=0.
REQ-025 SHALL, when done=1 and result_ready=1 on the same edge while result_valid=1, load the new result, keep result_valid=1, and leave overrun unchanged.
REQ-026 SHALL, when done=1 while result_valid=1 and result_ready=0, load the new result, keep result_valid=1, and set overrun=1.
REQ-027 SHALL hold overrun at 1 until reset.
REQ-028 SHALL keep slots and acc unchanged outside multiply and add cycles respectively.
REQ-029 SHALL provide a total latency of N+2 cycles, from the first multiply cycle to result_valid rising, under the controller sequence N×multiply, 1×add, 1×done.

Reset
REQ-030 SHALL, while reset=0, immediately force entry_count=0, result=0, result_valid=0, overrun=0, acc=0, and all slots=0, independent of clock.
REQ-031 SHALL, on reset assertion mid-operation, discard the partial operation; the next multiply cycle SHALL write slot 0.
REQ-032 SHALL resume normal operation on the first rising clock edge after reset returns to 1.

Verification
REQ-033 SHALL cover this scenario: 8 multiply cycles with a=1, b=1, then add, then done -> result=8, result_valid=1 ten cycles after the first multiply, entry_count sequence 0..7 then 0.
REQ-034 SHALL cover this scenario: a=255, b=255 on all 8 entries -> result=520200, with no wrap.
REQ-035 SHALL cover this scenario: a=i, b=i+1 for i=0..7 -> result=168; then result_ready=1 for one cycle -> result_valid=0 at the next edge.
REQ-036 SHALL cover this scenario: result_ready held 0, two back-to-back operations (all-ones, then a=2, b=3) -> result=48, result_valid=1, overrun=1.
REQ-037 SHALL cover this scenario: done and result_ready both high on one edge with result_valid=1 -> new result loaded, result_valid stays 1, overrun stays 0.
REQ-038 SHALL cover this scenario: reset pulled low while entry_count=4 -> entry_count, result_valid, and overrun read 0 before the next edge; a restart with a=1, b=1 -> result=8.
